lane_bit_demux: RTL

LANE_BIT_DEMUX -- requirements
Module: lane_bit_demux

---
 rtl/lane_bit_demux.sv | 86 ++++++++
 1 files changed

// File: rtl/lane_bit_demux.sv
// rtl/lane_bit_demux.sv - extracts strided lane bits from input words into per-lane frames
// Each accepted word contributes one bit per lane; WORDS words form one output frame.
module lane_bit_demux #(
  parameter int IN_W    = 16,
  parameter int LANES   = 4,
  parameter int BIT_OFS = 1,
  parameter int STRIDE  = 4,
  parameter int WORDS   = 1
) (
  input  logic                                         data_clk,
  input  logic                                         reset,
  input  logic [IN_W-1:0]                              data_in,
  input  logic                                         read,
  input  logic                                         flush,
  input  logic                                         out_ready,
  input  logic                                         clr_ovf,
  output logic [LANES*WORDS-1:0]                       out_data,
  output logic                                         out_valid,
  output logic [((WORDS > 1) ? $clog2(WORDS) : 1)-1:0] word_cnt,
  output logic                                         overflow
);

  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

  generate
    if ((BIT_OFS + (LANES - 1) * STRIDE >= IN_W) || (LANES < 1) || (STRIDE < 1) || (WORDS < 1)) begin : g_bad_params
      $error("lane_bit_demux: illegal parameter combination");
    end
  endgenerate

  logic [WORDS-1:0]       acc      [LANES];
  logic [WORDS-1:0]       acc_next [LANES];
  logic [LANES*WORDS-1:0] frame;
  logic                   accept;
  logic                   last_word;
  logic                   complete;
  logic                   ovf_event;

  assign accept    = read & ~flush;
  assign last_word = (word_cnt == CW'(WORDS - 1));
  assign complete  = accept & last_word;
  // A finished frame that cannot be handed over is dropped, not queued.
  assign ovf_event = complete & out_valid & ~out_ready;

  always_comb begin
    frame = '0;
    for (int k = 0; k < LANES; k++) begin
      acc_next[k] = (acc[k] << 1) | WORDS'(data_in[BIT_OFS + k * STRIDE]);
      frame[k * WORDS +: WORDS] = acc_next[k];
    end
  end

  always_ff @(posedge data_clk or posedge reset) begin
    if (reset) begin
      word_cnt  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      for (int k = 0; k < LANES; k++) acc[k] <= '0;
    end else begin
      if (flush) begin
        word_cnt <= '0;
        for (int k = 0; k < LANES; k++) acc[k] <= '0;
      end else if (accept) begin
        if (last_word) begin
          word_cnt <= '0;
          for (int k = 0; k < LANES; k++) acc[k] <= '0;
        end else begin
          word_cnt <= word_cnt + 1'b1;
          for (int k = 0; k < LANES; k++) acc[k] <= acc_next[k];
        end
      end

      if (complete && (!out_valid || out_ready)) begin
        out_data  <= frame;
        out_valid <= 1'b1;
      end else if (!complete && out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (ovf_event) overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

endmodule
